// File: rtl/prop_manager.sv
// Prop slot manager: Avalon-written prop slots, tank pickup detection and per-tank effects.
// Optional PROP_LIFETIME_EN: slot lifetimes count down on frame_tick and expire the prop.
module prop_manager #(
    parameter int TANK_NUM    = 2,
    parameter int PROP_NUM    = 4,
    parameter int WIDTH       = 32,
    parameter int HEIGHT      = 32,
    parameter int SPEED_TICKS = 300,
    parameter int ADDR_BASE   = 2087
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic [9:0]  tank_x [TANK_NUM],
    input  logic [9:0]  tank_y [TANK_NUM],
    input  logic        AVL_WRITE,
    input  logic [11:0] AVL_ADDR,
    input  logic [31:0] AVL_WRITEDATA,
    output logic [31:0] prop_reg_out [PROP_NUM],
    output logic        cure_pulse [TANK_NUM],
    output logic        speed_active [TANK_NUM],
    output logic [7:0]  pickup_cnt [TANK_NUM]
);
    localparam int CW = $clog2(SPEED_TICKS + 1);

    logic [PROP_NUM-1:0] wr_sel;
    logic [PROP_NUM-1:0] won_any;
    logic [PROP_NUM-1:0] is_cure;
    logic [PROP_NUM-1:0] is_speed;
    logic [PROP_NUM-1:0] hit [TANK_NUM];
    logic [PROP_NUM-1:0] win [TANK_NUM];

    // Lowest-index tank claims each slot; a same-cycle write to the slot blocks any claim.
    always_comb begin : win_arb
        logic [PROP_NUM-1:0] claimed;
        claimed = wr_sel;
        won_any = '0;
        for (int i = 0; i < TANK_NUM; i++) begin
            win[i] = hit[i] & ~claimed;
            won_any = won_any | win[i];
            claimed = claimed | hit[i];
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < PROP_NUM; gi++) begin : g_slot
            logic [31:0] slot_reg;
            logic [10:0] cx;
            logic [10:0] cy;

            assign wr_sel[gi]       = AVL_WRITE && (AVL_ADDR == 12'(ADDR_BASE + gi));
            assign is_cure[gi]      = (slot_reg[22:21] == 2'd0);
            assign is_speed[gi]     = (slot_reg[22:21] == 2'd1);
            assign cx               = {1'b0, slot_reg[10:1]} + 11'(WIDTH / 2);
            assign cy               = {1'b0, slot_reg[20:11]} + 11'(HEIGHT / 2);
            assign prop_reg_out[gi] = slot_reg;

            for (gj = 0; gj < TANK_NUM; gj++) begin : g_hit
                assign hit[gj][gi] = slot_reg[0]
                    && (cx >= {1'b0, tank_x[gj]}) && (cx < {1'b0, tank_x[gj]} + 11'(WIDTH))
                    && (cy >= {1'b0, tank_y[gj]}) && (cy < {1'b0, tank_y[gj]} + 11'(HEIGHT));
            end

            always_ff @(posedge CLK) begin
                if (!Reset) begin
                    slot_reg <= '0;
                end else if (wr_sel[gi]) begin
                    slot_reg <= AVL_WRITEDATA;
                end else if (won_any[gi]) begin
                    slot_reg[0] <= 1'b0;
`ifdef PROP_LIFETIME_EN
                // Lifetime 0 means the prop never expires.
                end else if (frame_tick && slot_reg[0] && (slot_reg[31:23] != 9'd0)) begin
                    slot_reg[31:23] <= slot_reg[31:23] - 9'd1;
                    if (slot_reg[31:23] == 9'd1) begin
                        slot_reg[0] <= 1'b0;
                    end
`endif
                end
            end
        end

        for (gi = 0; gi < TANK_NUM; gi++) begin : g_tank
            logic [CW-1:0] speed_reg;
            logic          cure_reg;
            logic [7:0]    pickup_reg;
            logic [9:0]    won_total;
            logic [9:0]    cnt_next;

            always_comb begin
                won_total = '0;
                for (int k = 0; k < PROP_NUM; k++) begin
                    won_total = won_total + 10'(win[gi][k]);
                end
            end
            assign cnt_next = 10'(pickup_reg) + won_total;

            always_ff @(posedge CLK) begin
                if (!Reset) begin
                    speed_reg  <= '0;
                    cure_reg   <= 1'b0;
                    pickup_reg <= '0;
                end else begin
                    cure_reg <= |(win[gi] & is_cure);
                    if (|(win[gi] & is_speed)) begin
                        speed_reg <= CW'(SPEED_TICKS);
                    end else if (frame_tick && (speed_reg != '0)) begin
                        speed_reg <= speed_reg - CW'(1);
                    end
                    pickup_reg <= (cnt_next > 10'd255) ? 8'hFF : cnt_next[7:0];
                end
            end

            assign cure_pulse[gi]   = cure_reg;
            assign speed_active[gi] = (speed_reg != '0);
            assign pickup_cnt[gi]   = pickup_reg;
        end
    endgenerate
endmodule

// File: tb/tb_prop_manager.sv
// Self-checking bench for prop_manager: directed scenarios plus randomized traffic
// against a slot/tank reference model.
module tb_prop_manager;
    localparam int TN = 2;
    localparam int PN = 4;
    localparam int W  = 32;
    localparam int H  = 32;
    localparam int ST = 300;
    localparam int AB = 2087;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        tick;
    logic [9:0]  tx [TN];
    logic [9:0]  ty [TN];
    logic        avl_wr;
    logic [11:0] avl_addr;
    logic [31:0] avl_data;
    logic [31:0] regs [PN];
    logic        cure [TN];
    logic        spd [TN];
    logic [7:0]  pick [TN];

    int vectors = 0;
    int miscompares = 0;

    bit [31:0] m_slot [PN];
    int        m_speed [TN];
    int        m_pick [TN];
    bit        m_cure [TN];

    always #5 clk = ~clk;

    prop_manager dut (
        .CLK(clk), .Reset(reset_n), .frame_tick(tick),
        .tank_x(tx), .tank_y(ty),
        .AVL_WRITE(avl_wr), .AVL_ADDR(avl_addr), .AVL_WRITEDATA(avl_data),
        .prop_reg_out(regs), .cure_pulse(cure), .speed_active(spd), .pickup_cnt(pick)
    );

    function automatic logic [31:0] mk(bit v, int x, int y, int t, int life);
        logic [31:0] w;
        w = '0;
        w[0] = v;
        w[10:1] = x[9:0];
        w[20:11] = y[9:0];
        w[22:21] = t[1:0];
        w[31:23] = life[8:0];
        return w;
    endfunction

    // Model: evaluate this cycle's inputs, advance one clock, commit.
    task automatic step();
        bit [31:0] ns [PN];
        int nsp [TN];
        int npk [TN];
        bit ncu [TN];
        bit load [TN];
        for (int i = 0; i < TN; i++) begin
            npk[i] = m_pick[i]; ncu[i] = 0; load[i] = 0; nsp[i] = m_speed[i];
        end
        for (int k = 0; k < PN; k++) ns[k] = m_slot[k];
        if (!reset_n) begin
            for (int k = 0; k < PN; k++) ns[k] = '0;
            for (int i = 0; i < TN; i++) begin npk[i] = 0; nsp[i] = 0; end
        end else begin
            for (int k = 0; k < PN; k++) begin
                int cx, cy, w, life;
                if (avl_wr && int'(avl_addr) == AB + k) begin
                    ns[k] = avl_data;
                end else if (m_slot[k][0]) begin
                    cx = int'(m_slot[k][10:1]) + W / 2;
                    cy = int'(m_slot[k][20:11]) + H / 2;
                    w = -1;
                    for (int i = 0; i < TN; i++)
                        if (w < 0 && cx >= int'(tx[i]) && cx < int'(tx[i]) + W &&
                            cy >= int'(ty[i]) && cy < int'(ty[i]) + H) w = i;
                    if (w >= 0) begin
                        ns[k][0] = 1'b0;
                        npk[w] = (npk[w] < 255) ? npk[w] + 1 : 255;
                        if (m_slot[k][22:21] == 2'd0) ncu[w] = 1;
                        else if (m_slot[k][22:21] == 2'd1) load[w] = 1;
                    end
`ifdef PROP_LIFETIME_EN
                    else if (tick) begin
                        life = int'(m_slot[k][31:23]);
                        if (life > 0) begin
                            life = life - 1;
                            ns[k][31:23] = life[8:0];
                            if (life == 0) ns[k][0] = 1'b0;
                        end
                    end
`endif
                end
            end
            for (int i = 0; i < TN; i++) begin
                if (load[i]) nsp[i] = ST;
                else if (tick && m_speed[i] > 0) nsp[i] = m_speed[i] - 1;
            end
        end
        @(posedge clk);
        for (int k = 0; k < PN; k++) m_slot[k] = ns[k];
        for (int i = 0; i < TN; i++) begin
            m_speed[i] = nsp[i]; m_pick[i] = npk[i]; m_cure[i] = ncu[i];
        end
        #1;
    endtask

    task automatic write_slot(int k, logic [31:0] d);
        avl_wr = 1'b1; avl_addr = 12'(AB + k); avl_data = d;
        step();
        avl_wr = 1'b0;
    endtask

    task automatic place(int i, int x, int y);
        tx[i] = x[9:0]; ty[i] = y[9:0];
    endtask

    task automatic test_reset();
        reset_n = 1'b0; place(0, 100, 100); place(1, 100, 100);
        avl_wr = 1'b1; avl_addr = 12'(AB); avl_data = mk(1, 100, 100, 0, 0);
        step();
        avl_wr = 1'b0; reset_n = 1'b1;
        for (int k = 0; k < PN; k++) begin
            vectors++;
            if (regs[k] !== 32'h0) begin
                miscompares++; $display("FAIL reset_slot%0d got %h want 0", k, regs[k]);
            end
        end
        for (int i = 0; i < TN; i++) begin
            vectors++;
            if (cure[i] !== 1'b0 || spd[i] !== 1'b0 || pick[i] !== 8'd0) begin
                miscompares++;
                $display("FAIL reset_tank%0d got cure=%b spd=%b pick=%0d want 0/0/0", i, cure[i], spd[i], pick[i]);
            end
        end
    endtask

    task automatic test_bad_addr();
        place(0, 900, 900); place(1, 900, 900);
        write_slot(PN, 32'h0);
        write_slot(PN, mk(1, 10, 10, 1, 5));
        write_slot(-1, mk(1, 10, 10, 1, 5));
        for (int k = 0; k < PN; k++) begin
            vectors++;
            if (regs[k] !== 32'h0) begin
                miscompares++; $display("FAIL bad_addr_slot%0d got %h want 0", k, regs[k]);
            end
        end
    endtask

    task automatic test_cure();
        int p0;
        place(0, 100, 100); place(1, 600, 600);
        p0 = m_pick[0];
        write_slot(0, mk(1, 100, 100, 0, 0));
        vectors++;
        if (regs[0] !== mk(1, 100, 100, 0, 0)) begin
            miscompares++; $display("FAIL cure_load got %h want %h", regs[0], mk(1, 100, 100, 0, 0));
        end
        step();
        vectors++;
        if (cure[0] !== 1'b1 || cure[1] !== 1'b0) begin
            miscompares++; $display("FAIL cure_pulse got %b%b want 1,0", cure[0], cure[1]);
        end
        vectors++;
        if (regs[0] !== mk(0, 100, 100, 0, 0)) begin
            miscompares++; $display("FAIL cure_clear got %h want %h", regs[0], mk(0, 100, 100, 0, 0));
        end
        vectors++;
        if (int'(pick[0]) !== p0 + 1) begin
            miscompares++; $display("FAIL cure_pick got %0d want %0d", pick[0], p0 + 1);
        end
        step();
        vectors++;
        if (cure[0] !== 1'b0) begin
            miscompares++; $display("FAIL cure_width got %b want 0", cure[0]);
        end
    endtask

    task automatic test_speed();
        int ticks;
        int p1;
        bit repicked;
        place(0, 200, 50); place(1, 200, 50);
        p1 = m_pick[1];
        write_slot(1, mk(1, 200, 50, 1, 0));
        step();
        vectors++;
        if (spd[0] !== 1'b1 || spd[1] !== 1'b0 || int'(pick[1]) !== p1) begin
            miscompares++;
            $display("FAIL speed_winner got spd=%b%b pick1=%0d want 1,0,%0d", spd[0], spd[1], pick[1], p1);
        end
        ticks = 0; repicked = 0;
        while (spd[0] === 1'b1 && ticks < 1000) begin
            if (ticks == 150 && !repicked) begin
                write_slot(1, mk(1, 200, 50, 1, 0));
                step();
                repicked = 1;
            end
            tick = 1'b1; step(); tick = 1'b0;
            ticks++;
            vectors++;
            if (spd[0] !== (m_speed[0] != 0)) begin
                miscompares++; $display("FAIL speed_track tick %0d got %b want %b", ticks, spd[0], m_speed[0] != 0);
            end
        end
        vectors++;
        if (ticks != 450) begin
            miscompares++; $display("FAIL speed_duration got %0d want 450", ticks);
        end
    endtask

    task automatic test_boundary();
        int xs [3] = '{116, 149, 117};
        bit hs [3] = '{0, 0, 1};
        place(1, 600, 600);
        for (int n = 0; n < 3; n++) begin
            place(0, 900, 900);
            write_slot(2, mk(1, 132, 100, 2, 0));
            place(0, xs[n], 100);
            step();
            vectors++;
            if (regs[2][0] !== !hs[n] || regs[2][0] !== m_slot[2][0]) begin
                miscompares++;
                $display("FAIL boundary x=%0d got valid=%b want %b", xs[n], regs[2][0], !hs[n]);
            end
        end
    endtask

    task automatic test_write_hit();
        int p0;
        place(0, 900, 900); place(1, 900, 900);
        write_slot(3, mk(1, 300, 300, 0, 0));
        p0 = m_pick[0];
        place(0, 300, 300);
        write_slot(3, mk(1, 700, 700, 1, 7));
        vectors++;
        if (regs[3] !== mk(1, 700, 700, 1, 7) || cure[0] !== 1'b0 || int'(pick[0]) !== p0) begin
            miscompares++;
            $display("FAIL write_hit got slot=%h cure=%b pick=%0d want %h,0,%0d",
                     regs[3], cure[0], pick[0], mk(1, 700, 700, 1, 7), p0);
        end
    endtask

    task automatic test_multi();
        int p0;
        place(0, 900, 0); place(1, 900, 500);
        for (int k = 0; k < PN; k++) write_slot(k, mk(1, 400, 400, k, 0));
        p0 = m_pick[0];
        place(0, 400, 400);
        step();
        vectors++;
        if (int'(pick[0]) !== p0 + 4 || cure[0] !== 1'b1 || spd[0] !== 1'b1 || cure[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL multi got pick=%0d cure=%b spd=%b want %0d,1,1", pick[0], cure[0], spd[0], p0 + 4);
        end
        for (int k = 0; k < PN; k++) begin
            vectors++;
            if (regs[k] !== mk(0, 400, 400, k, 0)) begin
                miscompares++; $display("FAIL multi_slot%0d got %h want %h", k, regs[k], mk(0, 400, 400, k, 0));
            end
        end
    endtask

    task automatic test_lifetime();
        bit exp_v;
        place(0, 900, 900); place(1, 900, 900);
        write_slot(0, mk(1, 800, 0, 0, 3));
        for (int t = 1; t <= 10; t++) begin
            tick = 1'b1; step(); tick = 1'b0;
`ifdef PROP_LIFETIME_EN
            exp_v = (t < 3);
`else
            exp_v = 1'b1;
`endif
            vectors++;
            if (regs[0][0] !== exp_v || regs[0] !== m_slot[0]) begin
                miscompares++;
                $display("FAIL lifetime tick %0d got %h want valid=%b slot=%h", t, regs[0], exp_v, m_slot[0]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        place(0, 300, 300); place(1, 900, 900);
        write_slot(1, mk(1, 300, 300, 1, 0));
        step();
        tick = 1'b1; step(); step(); tick = 1'b0;
        vectors++;
        if (spd[0] !== 1'b1) begin
            miscompares++; $display("FAIL midflight_active got %b want 1", spd[0]);
        end
        reset_n = 1'b0; step(); reset_n = 1'b1;
        vectors++;
        if (spd[0] !== 1'b0 || pick[0] !== 8'd0 || regs[1] !== 32'h0) begin
            miscompares++;
            $display("FAIL midflight_abort got spd=%b pick=%0d slot=%h want 0,0,0", spd[0], pick[0], regs[1]);
        end
    endtask

    task automatic test_saturate();
        reset_n = 1'b0; step(); reset_n = 1'b1;
        place(0, 0, 0); place(1, 900, 900);
        for (int c = 0; c < 280; c++) begin
            avl_wr = 1'b1; avl_addr = 12'(AB + (c % PN)); avl_data = mk(1, 0, 0, 2, 0);
            step();
        end
        avl_wr = 1'b0;
        step();
        vectors++;
        if (pick[0] !== 8'd255 || m_pick[0] != 255) begin
            miscompares++; $display("FAIL saturate got %0d want 255", pick[0]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset_n = ($urandom_range(0, 60) != 0);
            tick = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < TN; i++) place(i, $urandom_range(0, 100), $urandom_range(0, 100));
            avl_wr = ($urandom_range(0, 2) == 0);
            avl_addr = 12'(AB - 1 + $urandom_range(0, PN + 1));
            avl_data = mk($urandom_range(0, 3) != 0, $urandom_range(0, 100), $urandom_range(0, 100),
                          $urandom_range(0, 3), $urandom_range(0, 4));
            step();
            for (int k = 0; k < PN; k++) begin
                vectors++;
                if (regs[k] !== m_slot[k]) begin
                    miscompares++; $display("FAIL rand_slot%0d cyc %0d got %h want %h", k, c, regs[k], m_slot[k]);
                end
            end
            for (int i = 0; i < TN; i++) begin
                vectors++;
                if (cure[i] !== m_cure[i] || spd[i] !== (m_speed[i] != 0) || int'(pick[i]) !== m_pick[i]) begin
                    miscompares++;
                    $display("FAIL rand_tank%0d cyc %0d got cure=%b spd=%b pick=%0d want %b,%b,%0d",
                             i, c, cure[i], spd[i], pick[i], m_cure[i], m_speed[i] != 0, m_pick[i]);
                end
            end
        end
        reset_n = 1'b1; tick = 1'b0; avl_wr = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; tick = 1'b0; avl_wr = 1'b0; avl_addr = '0; avl_data = '0;
        for (int i = 0; i < TN; i++) begin tx[i] = '0; ty[i] = '0; end
        test_reset();
        test_bad_addr();
        test_cure();
        test_speed();
        test_boundary();
        test_write_hit();
        test_multi();
        test_lifetime();
        test_reset_midflight();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
